// File: rtl/exe_stage_mc_if.sv
// Issue, bypass and result bundle for the multi-cycle execute stage.
// The stage itself connects through the slave modport; the issuing side uses master.
interface exe_stage_mc_if #(
   parameter int DW   = 32,
   parameter int RW   = 6,
   parameter int NBYP = 2
);
   logic                 FREEZE;
   logic                 FLUSH;
   logic                 in_valid;
   logic                 in_ready;
   logic [3:0]           in_op;
   logic [DW-1:0]        in_opA;
   logic [DW-1:0]        in_opB;
   logic [RW-1:0]        in_rsA;
   logic [RW-1:0]        in_rsB;
   logic [RW-1:0]        in_rd;
   logic                 in_wb;
   logic [NBYP-1:0]      byp_valid;
   logic [NBYP*RW-1:0]   byp_reg;
   logic [NBYP*DW-1:0]   byp_data;
   logic                 out_valid;
   logic [DW-1:0]        out_result;
   logic [RW-1:0]        out_rd;
   logic                 out_wb;
   logic                 busy;

   modport master (
      output FREEZE, FLUSH, in_valid, in_op, in_opA, in_opB, in_rsA, in_rsB, in_rd, in_wb,
             byp_valid, byp_reg, byp_data,
      input  in_ready, out_valid, out_result, out_rd, out_wb, busy
   );

   modport slave (
      input  FREEZE, FLUSH, in_valid, in_op, in_opA, in_opB, in_rsA, in_rsB, in_rd, in_wb,
             byp_valid, byp_reg, byp_data,
      output in_ready, out_valid, out_result, out_rd, out_wb, busy
   );
endinterface

// File: rtl/exe_stage_mc.sv
// Execute stage with operand forwarding, single-cycle ALU and a multi-cycle
// MULTU/DIVU unit writing the HI/LO pair after a fixed busy window.
module exe_stage_mc #(
   parameter int DW      = 32,
   parameter int RW      = 6,
   parameter int NBYP    = 2,
   parameter int MUL_CYC = 4,
   parameter int DIV_CYC = DW
) (
   input logic           CLK,
   input logic           RESET,
   exe_stage_mc_if.slave bus
);
   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_AND   = 4'd2;
   localparam logic [3:0] OP_OR    = 4'd3;
   localparam logic [3:0] OP_XOR   = 4'd4;
   localparam logic [3:0] OP_SLTU  = 4'd5;
   localparam logic [3:0] OP_MULTU = 4'd6;
   localparam logic [3:0] OP_DIVU  = 4'd7;
   localparam logic [3:0] OP_MFHI  = 4'd8;
   localparam logic [3:0] OP_MFLO  = 4'd9;

   localparam int MAXC = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2
   } state_t;

   state_t          state_r, state_nxt_s;
   logic [CW-1:0]   cnt_r, cnt_nxt_s;
   logic [DW-1:0]   hi_r, hi_nxt_s, lo_r, lo_nxt_s;
   logic [DW-1:0]   pend_hi_r, pend_hi_nxt_s, pend_lo_r, pend_lo_nxt_s;
   logic            out_valid_r, out_valid_nxt_s, out_wb_r, out_wb_nxt_s;
   logic [DW-1:0]   out_result_r, out_result_nxt_s;
   logic [RW-1:0]   out_rd_r, out_rd_nxt_s;
   logic            busy_s, ready_s, accept_s;
   logic [DW-1:0]   opa_s, opb_s, alu_s, quo_s, rem_s;
   logic [2*DW-1:0] prod_s;

   // Own result beats every bypass; among bypasses the lowest index wins; r0 never forwards.
   function automatic logic [DW-1:0] resolve(
      input logic [RW-1:0]      src,
      input logic [DW-1:0]      opnd,
      input logic               own_en,
      input logic [RW-1:0]      own_rd,
      input logic [DW-1:0]      own_data,
      input logic [NBYP-1:0]    bv,
      input logic [NBYP*RW-1:0] br,
      input logic [NBYP*DW-1:0] bd
   );
      logic [DW-1:0] res;
      res = opnd;
      if (src != {RW{1'b0}}) begin
         for (int i = NBYP - 1; i >= 0; i--) begin
            if (bv[i] && (br[i*RW +: RW] == src)) begin
               res = bd[i*DW +: DW];
            end
         end
         if (own_en && (own_rd == src)) begin
            res = own_data;
         end
      end
      return res;
   endfunction

   assign busy_s   = (state_r != IDLE);
   assign ready_s  = !busy_s && !bus.FREEZE && !RESET;
   assign accept_s = bus.in_valid && ready_s && !bus.FLUSH;

   // Operand resolution and datapath results for the instruction being offered.
   always_comb begin
      opa_s  = resolve(bus.in_rsA, bus.in_opA, out_valid_r && out_wb_r, out_rd_r, out_result_r,
                       bus.byp_valid, bus.byp_reg, bus.byp_data);
      opb_s  = resolve(bus.in_rsB, bus.in_opB, out_valid_r && out_wb_r, out_rd_r, out_result_r,
                       bus.byp_valid, bus.byp_reg, bus.byp_data);
      prod_s = {{DW{1'b0}}, opa_s} * {{DW{1'b0}}, opb_s};
      if (opb_s == {DW{1'b0}}) begin
         quo_s = {DW{1'b1}};
         rem_s = opa_s;
      end else begin
         quo_s = opa_s / opb_s;
         rem_s = opa_s % opb_s;
      end
      case (bus.in_op)
         OP_ADD:  alu_s = opa_s + opb_s;
         OP_SUB:  alu_s = opa_s - opb_s;
         OP_AND:  alu_s = opa_s & opb_s;
         OP_OR:   alu_s = opa_s | opb_s;
         OP_XOR:  alu_s = opa_s ^ opb_s;
         OP_SLTU: alu_s = {{(DW-1){1'b0}}, (opa_s < opb_s)};
         OP_MFHI: alu_s = hi_r;
         OP_MFLO: alu_s = lo_r;
         default: alu_s = {DW{1'b0}};
      endcase
   end

   // FSM next state and next values of every register; FLUSH outranks FREEZE.
   always_comb begin
      state_nxt_s      = state_r;
      cnt_nxt_s        = cnt_r;
      hi_nxt_s         = hi_r;
      lo_nxt_s         = lo_r;
      pend_hi_nxt_s    = pend_hi_r;
      pend_lo_nxt_s    = pend_lo_r;
      out_valid_nxt_s  = out_valid_r;
      out_wb_nxt_s     = out_wb_r;
      out_result_nxt_s = out_result_r;
      out_rd_nxt_s     = out_rd_r;
      if (bus.FLUSH) begin
         out_valid_nxt_s = 1'b0;
         out_wb_nxt_s    = 1'b0;
         state_nxt_s     = IDLE;
         cnt_nxt_s       = {CW{1'b0}};
      end else if (bus.FREEZE) begin
         state_nxt_s = state_r;
      end else begin
         out_valid_nxt_s = 1'b0;
         out_wb_nxt_s    = 1'b0;
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  case (bus.in_op)
                     OP_MULTU: begin
                        pend_hi_nxt_s = prod_s[2*DW-1:DW];
                        pend_lo_nxt_s = prod_s[DW-1:0];
                        cnt_nxt_s     = CW'(MUL_CYC - 1);
                        state_nxt_s   = MUL;
                     end
                     OP_DIVU: begin
                        pend_hi_nxt_s = rem_s;
                        pend_lo_nxt_s = quo_s;
                        cnt_nxt_s     = CW'(DIV_CYC - 1);
                        state_nxt_s   = DIV;
                     end
                     default: begin
                        out_valid_nxt_s  = 1'b1;
                        out_result_nxt_s = alu_s;
                        out_rd_nxt_s     = bus.in_rd;
                        out_wb_nxt_s     = bus.in_wb;
                     end
                  endcase
               end else begin
                  state_nxt_s = IDLE;
               end
            end
            MUL, DIV: begin
               if (cnt_r == {CW{1'b0}}) begin
                  hi_nxt_s         = pend_hi_r;
                  lo_nxt_s         = pend_lo_r;
                  out_valid_nxt_s  = 1'b1;
                  out_result_nxt_s = pend_lo_r;
                  state_nxt_s      = IDLE;
               end else begin
                  cnt_nxt_s = cnt_r - CW'(1);
               end
            end
            default: begin
               state_nxt_s = IDLE;
               cnt_nxt_s   = {CW{1'b0}};
            end
         endcase
      end
   end

   // State, HI/LO and output registers.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_r      <= IDLE;
         cnt_r        <= {CW{1'b0}};
         hi_r         <= {DW{1'b0}};
         lo_r         <= {DW{1'b0}};
         pend_hi_r    <= {DW{1'b0}};
         pend_lo_r    <= {DW{1'b0}};
         out_valid_r  <= 1'b0;
         out_wb_r     <= 1'b0;
         out_result_r <= {DW{1'b0}};
         out_rd_r     <= {RW{1'b0}};
      end else begin
         state_r      <= state_nxt_s;
         cnt_r        <= cnt_nxt_s;
         hi_r         <= hi_nxt_s;
         lo_r         <= lo_nxt_s;
         pend_hi_r    <= pend_hi_nxt_s;
         pend_lo_r    <= pend_lo_nxt_s;
         out_valid_r  <= out_valid_nxt_s;
         out_wb_r     <= out_wb_nxt_s;
         out_result_r <= out_result_nxt_s;
         out_rd_r     <= out_rd_nxt_s;
      end
   end

   assign bus.in_ready   = ready_s;
   assign bus.busy       = busy_s;
   assign bus.out_valid  = out_valid_r;
   assign bus.out_wb     = out_wb_r;
   assign bus.out_result = out_result_r;
   assign bus.out_rd     = out_rd_r;
endmodule

// File: tb/tb_exe_stage_mc.sv
// Directed bench for exe_stage_mc: forwarding, bypass priority, MULTU/DIVU timing,
// FLUSH, FREEZE and asynchronous RESET behaviour with hand-computed results.
module tb_exe_stage_mc;
   localparam int DW   = 32;
   localparam int RW   = 6;
   localparam int NBYP = 2;

   logic clk = 1'b0;
   logic rst;
   int   pass_cnt  = 0;
   int   fail_cnt  = 0;
   int   total_cnt = 0;
   int   pulses;

   exe_stage_mc_if #(.DW(DW), .RW(RW), .NBYP(NBYP)) bus ();

   exe_stage_mc #(.DW(DW), .RW(RW), .NBYP(NBYP), .MUL_CYC(4), .DIV_CYC(32)) dut (
      .CLK  (clk),
      .RESET(rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] rsa, input logic [5:0] rsb,
                        input logic [5:0] rd, input logic wb);
      bus.in_op    = op;
      bus.in_opA   = a;
      bus.in_opB   = b;
      bus.in_rsA   = rsa;
      bus.in_rsB   = rsb;
      bus.in_rd    = rd;
      bus.in_wb    = wb;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
   endtask

   initial begin
      rst           = 1'b1;
      bus.FREEZE    = 1'b0;
      bus.FLUSH     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_op     = 4'd0;
      bus.in_opA    = 32'd0;
      bus.in_opB    = 32'd0;
      bus.in_rsA    = 6'd0;
      bus.in_rsB    = 6'd0;
      bus.in_rd     = 6'd0;
      bus.in_wb     = 1'b0;
      bus.byp_valid = 2'b00;
      bus.byp_reg   = 12'd0;
      bus.byp_data  = 64'd0;
      #1;
      check("rst_valid",  bus.out_valid,  64'd0);
      check("rst_result", bus.out_result, 64'd0);
      check("rst_busy",   bus.busy,       64'd0);
      check("rst_ready",  bus.in_ready,   64'd0);
      step();
      step();
      rst = 1'b0;
      #1;
      check("ready_after_rst", bus.in_ready, 64'd1);

      // own-output forwarding
      issue(4'd0, 32'd5, 32'd7, 6'd1, 6'd2, 6'd3, 1'b1);
      check("add_valid",  bus.out_valid,  64'd1);
      check("add_result", bus.out_result, 64'd12);
      check("add_rd",     bus.out_rd,     64'd3);
      issue(4'd0, 32'd0, 32'd1, 6'd3, 6'd4, 6'd5, 1'b1);
      check("fwd_own", bus.out_result, 64'd13);
      step();
      check("valid_pulse", bus.out_valid, 64'd0);

      issue(4'd1, 32'd3, 32'd5, 6'd0, 6'd0, 6'd6, 1'b0);
      check("sub_wrap", bus.out_result, 64'hFFFF_FFFE);
      check("sub_wb",   bus.out_wb,     64'd0);
      issue(4'd5, 32'd3, 32'd5, 6'd0, 6'd0, 6'd6, 1'b0);
      check("sltu_lt", bus.out_result, 64'd1);
      issue(4'd5, 32'hFFFF_FFFF, 32'd5, 6'd0, 6'd0, 6'd6, 1'b0);
      check("sltu_ge", bus.out_result, 64'd0);
      issue(4'd4, 32'hF0F0_00FF, 32'h0FF0_0F0F, 6'd0, 6'd0, 6'd6, 1'b0);
      check("xor", bus.out_result, 64'hFF00_0FF0);

      // bypass priority
      bus.byp_valid = 2'b11;
      bus.byp_reg   = {6'd9, 6'd9};
      bus.byp_data  = {32'hB, 32'hA};
      issue(4'd0, 32'h100, 32'd0, 6'd9, 6'd0, 6'd0, 1'b0);
      check("byp0_wins", bus.out_result, 64'hA);
      bus.byp_valid = 2'b10;
      issue(4'd0, 32'h100, 32'd0, 6'd9, 6'd0, 6'd0, 1'b0);
      check("byp1_only", bus.out_result, 64'hB);
      bus.byp_valid = 2'b11;
      bus.byp_reg   = {6'd0, 6'd0};
      issue(4'd0, 32'h100, 32'd0, 6'd0, 6'd0, 6'd0, 1'b1);
      check("r0_no_fwd", bus.out_result, 64'h100);
      bus.byp_valid = 2'b00;
      issue(4'd0, 32'h20, 32'd0, 6'd0, 6'd0, 6'd7, 1'b1);
      bus.byp_valid = 2'b01;
      bus.byp_reg   = {6'd0, 6'd7};
      issue(4'd0, 32'd0, 32'd1, 6'd7, 6'd0, 6'd8, 1'b0);
      check("own_over_byp", bus.out_result, 64'h21);
      bus.byp_valid = 2'b00;

      // MULTU
      issue(4'd6, 32'hFFFF_FFFF, 32'd2, 6'd0, 6'd0, 6'd0, 1'b0);
      check("mul_busy",  bus.busy,      64'd1);
      check("mul_ready", bus.in_ready,  64'd0);
      check("mul_nov",   bus.out_valid, 64'd0);
      step();
      step();
      step();
      check("mul_busy3", bus.busy,      64'd1);
      check("mul_early", bus.out_valid, 64'd0);
      step();
      check("mul_done_v",  bus.out_valid,  64'd1);
      check("mul_done_lo", bus.out_result, 64'hFFFF_FFFE);
      check("mul_done_wb", bus.out_wb,     64'd0);
      check("mul_idle",    bus.busy,       64'd0);
      issue(4'd8, 32'd0, 32'd0, 6'd0, 6'd0, 6'd1, 1'b1);
      check("mfhi_mul", bus.out_result, 64'd1);
      issue(4'd9, 32'd0, 32'd0, 6'd0, 6'd0, 6'd1, 1'b1);
      check("mflo_mul", bus.out_result, 64'hFFFF_FFFE);

      // DIVU 100/7
      issue(4'd7, 32'd100, 32'd7, 6'd0, 6'd0, 6'd0, 1'b0);
      for (int i = 0; i < 31; i++) step();
      check("div_busy31", bus.busy,      64'd1);
      check("div_early",  bus.out_valid, 64'd0);
      step();
      check("div_done_v",  bus.out_valid,  64'd1);
      check("div_quot",    bus.out_result, 64'd14);
      issue(4'd8, 32'd0, 32'd0, 6'd0, 6'd0, 6'd1, 1'b1);
      check("div_rem", bus.out_result, 64'd2);

      // DIVU by zero
      issue(4'd7, 32'd9, 32'd0, 6'd0, 6'd0, 6'd0, 1'b0);
      for (int i = 0; i < 32; i++) step();
      check("div0_lo", bus.out_result, 64'hFFFF_FFFF);
      issue(4'd8, 32'd0, 32'd0, 6'd0, 6'd0, 6'd1, 1'b1);
      check("div0_hi", bus.out_result, 64'd9);

      // FLUSH during DIV at counter 10
      issue(4'd7, 32'd50, 32'd5, 6'd0, 6'd0, 6'd0, 1'b0);
      for (int i = 0; i < 21; i++) step();
      bus.FLUSH = 1'b1;
      step();
      bus.FLUSH = 1'b0;
      check("flush_idle", bus.busy,      64'd0);
      check("flush_nov",  bus.out_valid, 64'd0);
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (bus.out_valid) pulses++;
      end
      check("flush_no_pulse", pulses, 64'd0);
      issue(4'd9, 32'd0, 32'd0, 6'd0, 6'd0, 6'd1, 1'b1);
      check("flush_lo_kept", bus.out_result, 64'hFFFF_FFFF);
      issue(4'd8, 32'd0, 32'd0, 6'd0, 6'd0, 6'd1, 1'b1);
      check("flush_hi_kept", bus.out_result, 64'd9);
      bus.FLUSH = 1'b1;
      issue(4'd0, 32'd1, 32'd1, 6'd0, 6'd0, 6'd2, 1'b1);
      bus.FLUSH = 1'b0;
      check("flush_discard_v",  bus.out_valid,  64'd0);
      check("flush_discard_wb", bus.out_wb,     64'd0);

      // FREEZE during MUL
      issue(4'd6, 32'd3, 32'd4, 6'd0, 6'd0, 6'd0, 1'b0);
      step();
      bus.FREEZE = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("frz_ready", bus.in_ready,  64'd0);
         check("frz_busy",  bus.busy,      64'd1);
         check("frz_nov",   bus.out_valid, 64'd0);
      end
      bus.FREEZE = 1'b0;
      step();
      step();
      check("frz_not_yet", bus.out_valid, 64'd0);
      step();
      check("frz_done_v",  bus.out_valid,  64'd1);
      check("frz_done_lo", bus.out_result, 64'd12);

      // RESET mid-MUL
      issue(4'd6, 32'd5, 32'd6, 6'd0, 6'd0, 6'd0, 1'b0);
      step();
      rst = 1'b1;
      #1;
      check("amid_result", bus.out_result, 64'd0);
      check("amid_busy",   bus.busy,       64'd0);
      check("amid_valid",  bus.out_valid,  64'd0);
      step();
      rst = 1'b0;
      issue(4'd0, 32'd1, 32'd1, 6'd0, 6'd0, 6'd2, 1'b1);
      check("post_rst_add", bus.out_result, 64'd2);
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (bus.out_valid) pulses++;
      end
      check("post_rst_no_pulse", pulses, 64'd0);
      issue(4'd9, 32'd0, 32'd0, 6'd0, 6'd0, 6'd1, 1'b1);
      check("post_rst_lo", bus.out_result, 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
